obi_mem_port_arbiter: RTL and testbench

Shares one OBI-style memory port between the core's instruction-fetch and data interfaces (req/gnt/rvalid protocol of riscv_core), so a single-ported memory or formal memory model can serve both. It sits between riscv_core and the memory. It arbitrates round-robin, holds the presented request stable until it is granted, and routes in-order responses back by tracking the source of every outstanding transaction.

---
 rtl/obi_arb_pkg.sv | 5 +
 rtl/obi_id_fifo.sv | 41 ++++
 rtl/obi_mem_port_arbiter.sv | 79 +++++++
 tb/tb_obi_mem_port_arbiter.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/obi_arb_pkg.sv
// obi_arb_pkg: shared source IDs and defaults for the OBI memory port arbiter.
package obi_arb_pkg;
  typedef enum logic {SRC_INSTR = 1'b0, SRC_DATA = 1'b1} src_e;
  localparam int DEFAULT_MAX_OUTSTANDING = 2;
endpackage

// File: rtl/obi_id_fifo.sv
// obi_id_fifo: in-order FIFO of source IDs for granted-but-unanswered transactions.
module obi_id_fifo
  import obi_arb_pkg::*;
#(
  parameter int DEPTH = DEFAULT_MAX_OUTSTANDING
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic push,
  input  logic pop,
  input  src_e din,
  output src_e dout,
  output logic full,
  output logic empty
);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  src_e mem [DEPTH];
  logic [PW-1:0] wptr, rptr;
  logic [CW-1:0] count;
  logic do_push, do_pop;
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign full    = count == CW'(DEPTH);
  assign empty   = count == '0;
  assign dout    = mem[rptr];
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wptr] <= din;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= (wptr == PW'(DEPTH - 1)) ? '0 : wptr + 1'b1;
      if (do_pop) rptr <= (rptr == PW'(DEPTH - 1)) ? '0 : rptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/obi_mem_port_arbiter.sv
// obi_mem_port_arbiter: round-robin sharing of one OBI memory port between fetch and data,
// holding the selection until granted and routing in-order responses by tracked source.
module obi_mem_port_arbiter
  import obi_arb_pkg::*;
#(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = DEFAULT_MAX_OUTSTANDING
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    instr_req_i,
  output logic                    instr_gnt_o,
  input  logic [ADDR_WIDTH-1:0]   instr_addr_i,
  output logic                    instr_rvalid_o,
  output logic [DATA_WIDTH-1:0]   instr_rdata_o,
  input  logic                    data_req_i,
  output logic                    data_gnt_o,
  input  logic                    data_we_i,
  input  logic [DATA_WIDTH/8-1:0] data_be_i,
  input  logic [ADDR_WIDTH-1:0]   data_addr_i,
  input  logic [DATA_WIDTH-1:0]   data_wdata_i,
  output logic                    data_rvalid_o,
  output logic [DATA_WIDTH-1:0]   data_rdata_o,
  output logic                    mem_req_o,
  input  logic                    mem_gnt_i,
  output logic                    mem_we_o,
  output logic [DATA_WIDTH/8-1:0] mem_be_o,
  output logic [ADDR_WIDTH-1:0]   mem_addr_o,
  output logic [DATA_WIDTH-1:0]   mem_wdata_o,
  input  logic                    mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0]   mem_rdata_i,
  output logic                    proto_err_o
);
  logic lock, full, empty, gnt, rsp;
  src_e locked_src, last_grant, winner, head;
  obi_id_fifo #(.DEPTH(MAX_OUTSTANDING)) u_fifo (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .push  (gnt),
    .pop   (rsp),
    .din   (winner),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );
  // A pending ungranted request keeps its source so the request fields stay stable.
  assign winner = lock ? locked_src
                : (instr_req_i & data_req_i) ? (last_grant == SRC_INSTR ? SRC_DATA : SRC_INSTR)
                : (data_req_i ? SRC_DATA : SRC_INSTR);
  assign mem_req_o   = (instr_req_i | data_req_i) & ~full;
  assign mem_we_o    = winner == SRC_DATA ? data_we_i : 1'b0;
  assign mem_be_o    = winner == SRC_DATA ? data_be_i : '1;
  assign mem_addr_o  = winner == SRC_DATA ? data_addr_i : instr_addr_i;
  assign mem_wdata_o = winner == SRC_DATA ? data_wdata_i : '0;
  assign gnt         = mem_gnt_i & mem_req_o;
  assign instr_gnt_o = gnt & (winner == SRC_INSTR);
  assign data_gnt_o  = gnt & (winner == SRC_DATA);
  assign rsp            = mem_rvalid_i & ~empty;
  assign instr_rvalid_o = rsp & (head == SRC_INSTR);
  assign data_rvalid_o  = rsp & (head == SRC_DATA);
  assign instr_rdata_o  = mem_rdata_i;
  assign data_rdata_o   = mem_rdata_i;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lock        <= 1'b0;
      locked_src  <= SRC_INSTR;
      last_grant  <= SRC_INSTR;
      proto_err_o <= 1'b0;
    end else begin
      if (mem_req_o) begin
        lock       <= ~mem_gnt_i;
        locked_src <= winner;
      end
      if (gnt) last_grant <= winner;
      if (mem_rvalid_i & empty) proto_err_o <= 1'b1;
    end
  end
endmodule

// File: tb/tb_obi_mem_port_arbiter.sv
// tb_obi_mem_port_arbiter: directed vectors with hand-computed expectations for the arbiter.
module tb_obi_mem_port_arbiter;
  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        instr_req_i = 1'b0, instr_gnt_o, instr_rvalid_o;
  logic [31:0] instr_addr_i = '0, instr_rdata_o;
  logic        data_req_i = 1'b0, data_gnt_o, data_we_i = 1'b0, data_rvalid_o;
  logic [3:0]  data_be_i = '0;
  logic [31:0] data_addr_i = '0, data_wdata_i = '0, data_rdata_o;
  logic        mem_req_o, mem_gnt_i = 1'b0, mem_we_o, mem_rvalid_i = 1'b0, proto_err_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i = '0;
  int checks = 0, errors = 0;
  obi_mem_port_arbiter dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .instr_req_i(instr_req_i), .instr_gnt_o(instr_gnt_o), .instr_addr_i(instr_addr_i),
    .instr_rvalid_o(instr_rvalid_o), .instr_rdata_o(instr_rdata_o),
    .data_req_i(data_req_i), .data_gnt_o(data_gnt_o), .data_we_i(data_we_i),
    .data_be_i(data_be_i), .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i),
    .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o),
    .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_rvalid_i(mem_rvalid_i),
    .mem_rdata_i(mem_rdata_i), .proto_err_o(proto_err_o)
  );
  always #5 clk_i = ~clk_i;
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask
  task automatic drive(input logic ir, input logic dr, input logic g, input logic rv, input logic [31:0] rd);
    instr_req_i  = ir;
    data_req_i   = dr;
    mem_gnt_i    = g;
    mem_rvalid_i = rv;
    mem_rdata_i  = rd;
    #1;
  endtask
  task automatic do_reset;
    drive(0, 0, 0, 0, 0);
    rst_ni = 1'b0;
    tick();
    tick();
    rst_ni = 1'b1;
  endtask
  initial begin
    do_reset();
    drive(0, 0, 0, 0, 0);
    check("rst_mem_req", mem_req_o, 0);
    check("rst_gnts", {instr_gnt_o, data_gnt_o}, 0);
    check("rst_rvalids", {instr_rvalid_o, data_rvalid_o}, 0);
    check("rst_proto_err", proto_err_o, 0);
    // instruction-only transaction
    instr_addr_i = 32'h1A00_0080;
    drive(1, 0, 1, 0, 0);
    check("i_mem_req", mem_req_o, 1);
    check("i_gnt", instr_gnt_o, 1);
    check("i_dgnt", data_gnt_o, 0);
    check("i_addr", mem_addr_o, 32'h1A00_0080);
    check("i_we_be", {mem_we_o, mem_be_o}, 5'b0_1111);
    tick();
    drive(0, 0, 0, 1, 32'h0000_0013);
    check("i_rvalid", instr_rvalid_o, 1);
    check("i_rdata", instr_rdata_o, 32'h0000_0013);
    check("i_drvalid", data_rvalid_o, 0);
    tick();
    // contention after reset, with responses overlapping grants
    do_reset();
    instr_addr_i = 32'h0000_0100;
    data_addr_i  = 32'h0000_2000;
    for (int i = 0; i < 4; i++) begin
      drive(1, 1, 1, i > 0, 32'hA0 + i);
      check($sformatf("c%0d_dgnt", i), data_gnt_o, (i % 2) == 0);
      check($sformatf("c%0d_ignt", i), instr_gnt_o, (i % 2) == 1);
      check($sformatf("c%0d_addr", i), mem_addr_o, (i % 2) == 0 ? 32'h2000 : 32'h100);
      check($sformatf("c%0d_rv", i), {instr_rvalid_o, data_rvalid_o},
            i == 0 ? 2'b00 : ((i % 2) == 1 ? 2'b01 : 2'b10));
      check($sformatf("c%0d_rdata", i), data_rdata_o, 32'hA0 + i);
      tick();
    end
    drive(0, 0, 0, 1, 32'h55);
    check("c_last_rv", {instr_rvalid_o, data_rvalid_o}, 2'b10);
    tick();
    drive(0, 0, 0, 0, 0);
    check("c_drained_mem_req", mem_req_o, 0);
    // lock stability
    do_reset();
    instr_addr_i = 32'h0000_0080;
    data_addr_i  = 32'h0000_1000;
    data_we_i    = 1'b1;
    data_be_i    = 4'h3;
    data_wdata_i = 32'hDEAD_BEEF;
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 0, 0, 0);
      check($sformatf("l%0d_addr", i), mem_addr_o, 32'h1000);
      check($sformatf("l%0d_gnts", i), {instr_gnt_o, data_gnt_o}, 2'b00);
      tick();
    end
    drive(1, 1, 1, 0, 0);
    check("l3_addr", mem_addr_o, 32'h1000);
    check("l3_dgnt", data_gnt_o, 1);
    check("l3_fields", {mem_we_o, mem_be_o, mem_wdata_o}, {1'b1, 4'h3, 32'hDEAD_BEEF});
    tick();
    drive(1, 1, 1, 0, 0);
    check("l4_ignt", instr_gnt_o, 1);
    tick();
    // FIFO full (DATA, INSTR outstanding)
    drive(1, 1, 1, 0, 0);
    check("f_mem_req", mem_req_o, 0);
    check("f_gnts", {instr_gnt_o, data_gnt_o}, 2'b00);
    tick();
    drive(1, 1, 0, 1, 32'h77);
    check("f_pop_rv", {instr_rvalid_o, data_rvalid_o}, 2'b01);
    check("f_pop_req", mem_req_o, 0);
    tick();
    drive(1, 1, 0, 0, 0);
    check("f_reopen", mem_req_o, 1);
    tick();
    drive(0, 0, 0, 1, 32'h88);
    check("f_last_rv", {instr_rvalid_o, data_rvalid_o}, 2'b10);
    tick();
    // spurious response
    drive(0, 0, 0, 1, 32'h99);
    check("s_rv", {instr_rvalid_o, data_rvalid_o}, 2'b00);
    check("s_err_pre", proto_err_o, 0);
    tick();
    drive(0, 0, 0, 0, 0);
    check("s_err", proto_err_o, 1);
    tick();
    check("s_err_sticky", proto_err_o, 1);
    rst_ni = 1'b0;
    #1;
    check("s_err_rst", proto_err_o, 0);
    rst_ni = 1'b1;
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
